// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg
//   Shared definitions for the uart_lite receive path: the controller FSM
//   state encoding and the default character framing shared with the
//   character_recovery engine.
package uart_lite_pkg;

    // Framing defaults; the controller and the engine must agree on these.
    localparam int OVERSAMPLING_DEF = 16;
    localparam int DATA_BITS_DEF    = 8;

    // Controller FSM state encoding.
    localparam logic [0:0] ST_INIT = 1'b0;  // engine held in reset, waiting for idle line
    localparam logic [0:0] ST_RUN  = 1'b1;  // engine running, characters accepted

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Synchronous character FIFO for the uart_lite receive path.
//   A push on a full FIFO is only accepted when a pop happens in the same
//   cycle; otherwise it is ignored (the caller flags the overrun).
//   A pop on an empty FIFO has no effect.
// Ports
//   clk_i    in   sole clock
//   rst_i    in   synchronous active-high reset, empties the FIFO
//   push_i   in   write data_i this cycle
//   data_i   in   character to write
//   pop_i    in   remove the head this cycle
//   data_o   out  head of the FIFO (valid while empty_o is low)
//   full_o   out  FIFO holds FIFO_DEPTH entries
//   empty_o  out  FIFO holds no entries
//   level_o  out  occupancy, 0..FIFO_DEPTH
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            push_i,
    input  logic [DATA_BITS-1:0]            data_i,
    input  logic                            pop_i,
    output logic [DATA_BITS-1:0]            data_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(FIFO_DEPTH):0]     level_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 do_push;
    logic                 do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(FIFO_DEPTH));
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        // A pop in the same cycle frees the slot, so a push at full still lands.
        do_push = push_i && (!full_o || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller
//   Sequences the uart_lite character_recovery engine:
//   - two-flop synchroniser on the RX pad, inverted into the engine's
//     start=1/stop=0 polarity (rec_rx_o),
//   - oversample strobe generator driven by a runtime divisor (rec_valid_o),
//   - INIT/RUN FSM holding the engine in reset until the line has been idle
//     for OVERSAMPLING consecutive strobes (rec_rst_o),
//   - character FIFO with valid/ready output and sticky overrun flag.
//   Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined;
//   otherwise break_o is tied low.
// Handshake: data_o/valid_o form a valid/ready source; a character leaves the
//   FIFO on every cycle where valid_o && ready_i, and data_o holds steady while
//   valid_o && !ready_i.
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   rx_i                   asynchronous RX pad, idle high
//   div_i, div_we_i        divisor load (clocks per oversample strobe)
//   rec_rx_o, rec_valid_o, rec_rst_o   to the engine
//   rec_char_i, rec_valid_i            from the engine
//   data_o, valid_o, ready_i, level_o  character FIFO output
//   overrun_o, ovr_clr_i               sticky overrun and its clear
//   break_o                            line-break indication
module uart_rx_controller
    import uart_lite_pkg::*;
#(
    parameter int OVERSAMPLING = OVERSAMPLING_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_W        = 16,
    parameter int DIV_RESET    = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    input  logic [DIV_W-1:0]              div_i,
    input  logic                          div_we_i,
    output logic                          rec_rx_o,
    output logic                          rec_valid_o,
    output logic                          rec_rst_o,
    input  logic [DATA_BITS-1:0]          rec_char_i,
    input  logic                          rec_valid_i,
    output logic [DATA_BITS-1:0]          data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overrun_o,
    input  logic                          ovr_clr_i,
    output logic                          break_o
);
    localparam int IDLE_W = $clog2(OVERSAMPLING + 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [0:0]           state_q, state_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                 overrun_q, overrun_d;

    logic [DIV_W-1:0]     eff_div;
    logic                 strobe;
    logic                 rec_rx;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign rec_rx      = ~sync2_q;
    assign rec_rx_o    = rec_rx;
    assign rec_valid_o = strobe;
    assign rec_rst_o   = (state_q == ST_INIT);
    assign valid_o     = !fifo_empty;
    assign overrun_o   = overrun_q;

    // Engine output is meaningless while it is held in reset.
    assign push = rec_valid_i && (state_q == ST_RUN);
    assign pop  = valid_o && ready_i;

    always_comb begin
        sync1_d = rx_i;
        sync2_d = sync1_q;

        // A divisor of 0 behaves like 1: a strobe every cycle.
        eff_div = (div_q == '0) ? DIV_W'(1) : div_q;
        strobe  = (cnt_q == eff_div - DIV_W'(1));

        div_d      = div_q;
        cnt_d      = strobe ? '0 : cnt_q + DIV_W'(1);
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;

        if (div_we_i) begin
            // New rate: restart the strobe phase and re-qualify the line.
            div_d      = div_i;
            cnt_d      = '0;
            state_d    = ST_INIT;
            idle_cnt_d = '0;
        end else if (strobe && (state_q == ST_INIT)) begin
            if (rec_rx) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_W'(OVERSAMPLING - 1)) begin
                // This strobe is the OVERSAMPLING-th consecutive idle one.
                state_d    = ST_RUN;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
        end

        // Setting beats clearing when both happen together.
        overrun_d = overrun_q;
        if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            div_q      <= DIV_W'(DIV_RESET);
            cnt_q      <= '0;
            state_q    <= ST_INIT;
            idle_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    // A break is a low pad held for a whole frame: start, data and stop bits.
    localparam int BRK_MAX = (DATA_BITS + 2) * OVERSAMPLING;
    localparam int BRK_W   = $clog2(BRK_MAX + 1);

    logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;

    always_comb begin
        brk_cnt_d = brk_cnt_q;
        if (div_we_i) begin
            brk_cnt_d = '0;
        end else if (strobe) begin
            if (!rec_rx) begin
                brk_cnt_d = '0;
            end else if (brk_cnt_q != BRK_W'(BRK_MAX)) begin
                brk_cnt_d = brk_cnt_q + BRK_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            brk_cnt_q <= '0;
        end else begin
            brk_cnt_q <= brk_cnt_d;
        end
    end

    assign break_o = (brk_cnt_q == BRK_W'(BRK_MAX));
`else
    assign break_o = 1'b0;
`endif

    uart_rx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (rec_char_i),
        .pop_i   (pop),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller
//   Bench for uart_rx_controller. A reference model evaluated every cycle
//   predicts the strobe, pad, engine-reset, break and FIFO outputs; accepted
//   characters are pushed to exp_q and compared against data_o on each pop.
//   Break expectations follow UART_RX_BREAK_DETECT_EN.
module tb_uart_rx_controller;

    localparam int DB      = 8;
    localparam int DEPTH   = 4;
    localparam int DIV_W   = 16;
    localparam int OS      = 16;
    localparam int BRK_MAX = (DB + 2) * OS;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_i;
    logic             rx_i;
    logic [DIV_W-1:0] div_i;
    logic             div_we_i;
    logic             rec_rx_o;
    logic             rec_valid_o;
    logic             rec_rst_o;
    logic [DB-1:0]    rec_char_i;
    logic             rec_valid_i;
    logic [DB-1:0]    data_o;
    logic             valid_o;
    logic             ready_i;
    logic [2:0]       level_o;
    logic             overrun_o;
    logic             ovr_clr_i;
    logic             break_o;

    always #5 clk = ~clk;

    uart_rx_controller dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .div_i       (div_i),
        .div_we_i    (div_we_i),
        .rec_rx_o    (rec_rx_o),
        .rec_valid_o (rec_valid_o),
        .rec_rst_o   (rec_rst_o),
        .rec_char_i  (rec_char_i),
        .rec_valid_i (rec_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
        .overrun_o   (overrun_o),
        .ovr_clr_i   (ovr_clr_i),
        .break_o     (break_o)
    );

    // ---------------- scoreboard state ----------------
    logic [DB-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Strobes fall on every eff_div-th cycle counted from the last reset or
    // divisor write; the engine leaves reset after 16 consecutive idle
    // strobes; the pad reaches rec_rx_o inverted two clocks later.
    bit m_known = 1'b0;
    int m_div, m_t, m_idle, m_brk, m_eff;
    bit m_run, m_ovr, m_strobe, m_rx, m_pop, m_push;
    bit pad_q[$];

    always @(negedge clk) begin : model
        if (m_known) begin
            m_eff    = (m_div == 0) ? 1 : m_div;
            m_strobe = ((m_t + 1) % m_eff) == 0;
            m_rx     = !pad_q[0];
            chk("rec_valid", rec_valid_o, m_strobe);
            chk("rec_rx", rec_rx_o, m_rx);
            chk("rec_rst", rec_rst_o, !m_run);
            chk("break", break_o, BRK_EN && (m_brk == BRK_MAX));
            chk("valid", valid_o, exp_q.size() != 0);
            chk("level", level_o, exp_q.size());
            chk("overrun", overrun_o, m_ovr);
            if (exp_q.size() != 0) chk("data", data_o, exp_q[0]);
        end
        if (rst_i) begin
            m_known = 1'b1;
            m_div = 1; m_t = 0; m_idle = 0; m_brk = 0;
            m_run = 1'b0; m_ovr = 1'b0;
            exp_q.delete();
            pad_q.delete(); pad_q.push_back(1'b1); pad_q.push_back(1'b1);
        end else if (m_known) begin
            void'(pad_q.pop_front());
            pad_q.push_back(rx_i);
            m_pop  = (exp_q.size() != 0) && ready_i;
            m_push = rec_valid_i && m_run;
            if (m_pop) void'(exp_q.pop_front());
            if (m_push && exp_q.size() == DEPTH) m_ovr = 1'b1;
            else if (ovr_clr_i) m_ovr = 1'b0;
            if (m_push && exp_q.size() < DEPTH) exp_q.push_back(rec_char_i);
            if (div_we_i) begin
                m_div = int'(div_i); m_t = 0; m_run = 1'b0; m_idle = 0; m_brk = 0;
            end else begin
                m_t++;
                if (m_strobe) begin
                    if (m_rx) begin
                        m_idle = 0;
                        if (m_brk < BRK_MAX) m_brk++;
                    end else begin
                        m_idle++;
                        m_brk = 0;
                    end
                    if (m_idle >= OS) m_run = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DB-1:0] c);
        rec_char_i  = c;
        rec_valid_i = 1'b1;
        tick();
        rec_valid_i = 1'b0;
    endtask

    task automatic wr_div(input int d);
        div_i    = DIV_W'(d);
        div_we_i = 1'b1;
        tick();
        div_we_i = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n, k;
        rst_i = 1'b1; rx_i = 1'b1; div_i = '0; div_we_i = 1'b0;
        rec_char_i = '0; rec_valid_i = 1'b0; ready_i = 1'b0; ovr_clr_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;

        // Engine reset spans exactly 16 strobes at div=1.
        n = 0; k = 0;
        while (rec_rst_o && k < 100) begin
            if (rec_valid_o) n++;
            tick();
            k++;
        end
        chk("init_strobes", n, 16);

        // Divisor 3: first strobe three cycles after the write.
        wr_div(3);
        chk("div3_init", rec_rst_o, 1);
        k = 1;
        while (!rec_valid_o && k < 10) begin
            tick();
            k++;
        end
        chk("div3_first", k, 3);
        repeat (60) tick();

        // Two characters held, then drained back to back.
        send(8'hA5); send(8'h3C); tick();
        ready_i = 1'b1; repeat (3) tick(); ready_i = 1'b0;

        // Fill, overflow, push+pop at full, clear racing an overflow.
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
        ready_i = 1'b1; send(8'h77); ready_i = 1'b0;
        ovr_clr_i = 1'b1; send(8'h88); ovr_clr_i = 1'b0;
        tick();
        ovr_clr_i = 1'b1; tick(); ovr_clr_i = 1'b0;
        ready_i = 1'b1; repeat (6) tick(); ready_i = 1'b0;

        // Randomised traffic, divisor rewrites and pad glitches.
        for (int i = 0; i < 500; i++) begin
            rec_valid_i = ($urandom_range(0, 2) == 0);
            rec_char_i  = 8'($urandom);
            ready_i     = ($urandom_range(0, 3) != 0) ? (i % 64 < 40) : 1'b0;
            ovr_clr_i   = ($urandom_range(0, 15) == 0);
            div_we_i    = ($urandom_range(0, 99) == 0);
            div_i       = DIV_W'($urandom_range(0, 3));
            rx_i        = (i < 200 && $urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rec_valid_i = 1'b0; ovr_clr_i = 1'b0; div_we_i = 1'b0; rx_i = 1'b1;
        ready_i = 1'b1; repeat (5) tick(); ready_i = 1'b0;

        // Line break from RUN at div=1.
        wr_div(1);
        repeat (20) tick();
        rx_i = 1'b0;
        repeat (170) tick();
        chk("break_set", break_o, BRK_EN);
        rx_i = 1'b1;
        repeat (5) tick();
        chk("break_clr", break_o, 0);

        // Reset mid-character with two characters buffered.
        send(8'h11); send(8'h22);
        rx_i = 1'b0; repeat (3) tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("rst_level", level_o, 0);
        chk("rst_engine", rec_rst_o, 1);
        rx_i = 1'b1;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
